hps_reset_sequencer: RTL and testbench
======================================

HPS_RESET_SEQUENCER -- requirements
Module: hps_reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 3: number of reset-request channels; channel 0 has highest priority.
REQ-002 Parameter CNT_W, default 8: pulse and gap counter width.
REQ-003 Parameter PULSE_LEN, default {8'd32,8'd2,8'd6}: packed NUM_CH*CNT_W vector; slice i is the channel-i pulse length in cycles; valid range 1..2^CNT_W-1.
REQ-004 Parameter EDGE_MODE, default {2'd1,2'd1,2'd1}: packed NUM_CH*2 vector; per-channel trigger: 0 falling, 1 rising, 2 both, 3 disabled.
REQ-005 Parameter SYNC_STAGES, default 2: input synchronizer depth; valid range 2..4.
REQ-006 Parameter GAP_CYCLES, default 4: minimum idle cycles between consecutive pulses; 0 is allowed.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 req_in  in  NUM_CH  asynchronous request levels.
REQ-010 enable  in  1  when 0, new edges are not latched.
REQ-011 clear_overrun  in  1  single-cycle strobe that clears overrun.
REQ-012 pulse_out  out  NUM_CH  registered active-high reset pulses; at most one bit is high at a time.
REQ-013 pending  out  NUM_CH  latched requests awaiting dispatch.
REQ-014 overrun  out  NUM_CH  sticky flag: an edge arrived while the same channel was already pending.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 Each req_in bit passes through a SYNC_STAGES flop chain; one further flop (prev) holds the last synchronized value.
REQ-017 An edge is the comparison of chain output against prev, qualified per EDGE_MODE; edge detection is masked for SYNC_STAGES+1 cycles after reset deasserts.
REQ-018 On a qualified edge with enable=1: pending[i] sets on the next edge; if pending[i] is already 1 and is not being dispatched that cycle, overrun[i] also sets.
REQ-019 Edge on a channel in the same cycle that channel is dispatched: pending[i] stays 1 (new request queued), overrun unchanged.
REQ-020 The FSM has three states: IDLE, PULSE, GAP.
REQ-021 IDLE: if any pending bit is 1, select the lowest index, clear its pending bit, load the counter with PULSE_LEN[i], go to PULSE.
REQ-022 PULSE: pulse_out[sel] is high for exactly PULSE_LEN[sel] cycles; on the last cycle, go to GAP with the counter loaded to GAP_CYCLES, or go to IDLE if GAP_CYCLES=0.
REQ-023 GAP: all pulse_out bits are 0 for exactly GAP_CYCLES cycles, then go to IDLE; edges are still latched during GAP.
REQ-024 Latency: req_in is sampled at edge k; pending is 1 after edge k+SYNC_STAGES; pulse_out is high after edge k+SYNC_STAGES+1 when the FSM is IDLE.
REQ-025 A pulse in progress is never pre-empted; a higher-priority request waits for PULSE and GAP to finish.
REQ-026 enable=0 blocks only new latching; pending requests and the active pulse complete normally.
REQ-027 clear_overrun clears all overrun bits; if it coincides with a new overrun event, the set wins.
REQ-028 Counters never wrap: a counter is loaded only on state entry and decrements to its terminal value.

Reset
REQ-029 While reset=1: pulse_out=0, pending=0, overrun=0, busy=0, FSM=IDLE, sync and prev flops=0, mask counter loaded; effective on the next clk edge, including mid-pulse.

Verification
REQ-030 Defaults, rising edge on req_in[1] -> pulse_out[1] high 2 cycles, starting 3 cycles after sampling; busy high for 2+4 cycles.
REQ-031 Rising edges on ch0 and ch2 in the same cycle -> ch0 pulses 6 cycles, 4-cycle gap, then ch2 pulses 32 cycles; pending[2] high until ch2 dispatch.
REQ-032 Two ch2 edges while ch2 is pending -> overrun[2]=1 and a single ch2 pulse; clear_overrun -> overrun[2]=0 next cycle.
REQ-033 Assert reset during cycle 10 of a ch2 pulse -> pulse_out=0 next cycle; req_in held high through reset release -> no pulse.
REQ-034 enable=0, edge on ch0 -> no pending, no pulse; EDGE_MODE=2 with enable=1, high then low toggle -> two pulses separated by the gap.

Source files
------------

// File: rtl/hps_reset_sequencer.sv
// Reset-pulse sequencer: synchronizes per-channel request lines, latches qualified
// edges as pending requests and dispatches them one at a time as fixed-length pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no pulse active; lowest-index pending request dispatched
// S_PULSE | pulse_out[sel] high, counter counts down the pulse length
// S_GAP   | all pulses low, counter counts down the minimum idle gap
module hps_reset_sequencer #(
  parameter int                        NUM_CH      = 3,
  parameter int                        CNT_W       = 8,
  parameter logic [NUM_CH*CNT_W-1:0]   PULSE_LEN   = {8'd32, 8'd2, 8'd6},
  parameter logic [NUM_CH*2-1:0]       EDGE_MODE   = {2'd1, 2'd1, 2'd1},
  parameter int                        SYNC_STAGES = 2,
  parameter int                        GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_in,
  input  logic              enable,
  input  logic              clear_overrun,
  output logic [NUM_CH-1:0] pulse_out,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun,
  output logic              busy
);

  localparam int                SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0]        MASK_INIT = 3'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] edge_hit;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] dispatch;
  logic [2:0]        mask_cnt;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  sel_next;
  logic [CNT_W-1:0]  pulse_load;
  logic              any_pend;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign busy     = (state != S_IDLE);
  assign any_pend = |pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_out;
    end
  end

  // Edges are ignored until the synchronizer has flushed the reset zeros.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_cnt <= MASK_INIT;
    end else if (mask_cnt != 3'd0) begin
      mask_cnt <= mask_cnt - 1'b1;
    end
  end

  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (EDGE_MODE[2*i +: 2])
        2'd0:    edge_hit[i] = ~sync_out[i] & prev_q[i];
        2'd1:    edge_hit[i] = sync_out[i] & ~prev_q[i];
        2'd2:    edge_hit[i] = sync_out[i] ^ prev_q[i];
        default: edge_hit[i] = 1'b0;
      endcase
    end
  end

  assign edge_q = edge_hit & {NUM_CH{enable && (mask_cnt == 3'd0)}};

  always_comb begin
    sel_next = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) sel_next = SEL_W'(i);
    end
  end

  assign pulse_load = PULSE_LEN[sel_next*CNT_W +: CNT_W];
  assign dispatch   = (state == S_IDLE && any_pend) ? (NUM_CH'(1) << sel_next) : '0;

  // A new edge on the channel being dispatched re-queues it without flagging overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~dispatch) | edge_q;
      overrun <= (clear_overrun ? '0 : overrun) | (edge_q & pending & ~dispatch);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pulse_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_pend) begin
            state     <= S_PULSE;
            cnt       <= pulse_load;
            pulse_out <= dispatch;
          end
        end
        S_PULSE: begin
          if (cnt <= CNT_W'(1)) begin
            pulse_out <= '0;
            if (GAP_CYCLES == 0) begin
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt <= CNT_W'(1)) state <= S_IDLE;
          else                  cnt   <= cnt - 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          pulse_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Directed bench for hps_reset_sequencer: expected pulses are queued as stimulus is
// driven and compared against the pulses the sequencer emits.
module tb_hps_reset_sequencer;

  localparam int GAP = 4;

  typedef struct {
    int ch;
    int len;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] req_in;
  logic       enable;
  logic       clear_overrun;
  logic [2:0] pulse_out;
  logic [2:0] pending;
  logic [2:0] overrun;
  logic       busy;

  int         checks;
  int         errors;
  exp_t       sb_q[$];
  logic [2:0] pend_at_start;

  hps_reset_sequencer #(
    .EDGE_MODE ({2'd1, 2'd1, 2'd2})
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_in        (req_in),
    .enable        (enable),
    .clear_overrun (clear_overrun),
    .pulse_out     (pulse_out),
    .pending       (pending),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int ch, input int len);
    exp_t e;
    e.ch  = ch;
    e.len = len;
    sb_q.push_back(e);
  endtask

  // Pops one expected pulse, then measures start channel, length and trailing gap.
  task automatic run_pulse_sb(input string tag);
    exp_t       e;
    int         n;
    int         len;
    int         gap;
    logic [2:0] oh;
    e = sb_q.pop_front();
    n = 0;
    while (pulse_out == 3'b000 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " start_in_time"}, int'(n < 300), 1);
    pend_at_start = pending;
    check({tag, " channel"}, int'(pulse_out), 1 << e.ch);
    oh  = pulse_out;
    len = 0;
    while (pulse_out == oh && oh != 3'b000 && len < 300) begin
      len++;
      @(negedge clk);
    end
    check({tag, " length"}, len, e.len);
    check({tag, " gap_quiet"}, int'(pulse_out), 0);
    gap = 0;
    while (busy && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    check({tag, " gap_len"}, gap, GAP);
  endtask

  task automatic idle_window(input string tag, input int n);
    int act;
    act = 0;
    repeat (n) begin
      @(negedge clk);
      if (pulse_out != 3'b000 || busy) act++;
    end
    check(tag, act, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    req_in        = 3'b000;
    enable        = 1'b1;
    clear_overrun = 1'b0;
    tick(3);
    check("reset pulse_out", int'(pulse_out), 0);
    check("reset pending", int'(pending), 0);
    check("reset overrun", int'(overrun), 0);
    check("reset busy", int'(busy), 0);
    reset = 1'b0;
    tick(8);

    // Single rising edge on ch1: latency, 2-cycle pulse, 4-cycle gap.
    req_in[1] = 1'b1;
    tick(1);
    check("r030 pending k", int'(pending), 0);
    tick(1);
    check("r030 pending k+1", int'(pending), 0);
    tick(1);
    check("r030 pending k+2", int'(pending), 3'b010);
    tick(1);
    check("r030 pulse k+3", int'(pulse_out), 3'b010);
    check("r030 busy k+3", int'(busy), 1);
    check("r030 pending cleared", int'(pending), 0);
    push_exp(1, 2);
    run_pulse_sb("r030");
    req_in[1] = 1'b0;
    idle_window("r030 ch1 fall ignored", 10);

    // Simultaneous ch0/ch2: priority order, ch2 stays pending meanwhile.
    req_in = 3'b101;
    push_exp(0, 6);
    push_exp(2, 32);
    run_pulse_sb("r031 ch0");
    check("r031 pend2 at ch0 start", int'(pend_at_start), 3'b100);
    check("r031 pend2 after gap", int'(pending), 3'b100);
    run_pulse_sb("r031 ch2");
    check("r031 pend after ch2 start", int'(pend_at_start), 0);
    req_in = 3'b000;
    push_exp(0, 6);
    run_pulse_sb("r031 ch0 fall");
    idle_window("r031 quiet", 10);

    // Repeated ch2 edges while pending -> overrun, still a single ch2 pulse.
    req_in[0] = 1'b1;
    push_exp(0, 6);
    push_exp(2, 32);
    fork
      begin
        tick(1);
        req_in[2] = 1'b1;
        tick(4);
        req_in[2] = 1'b0;
        tick(4);
        req_in[2] = 1'b1;
        tick(3);
        check("r032 overrun set", int'(overrun), 3'b100);
        check("r032 pending held", int'(pending), 3'b100);
      end
      begin
        run_pulse_sb("r032 ch0");
        run_pulse_sb("r032 ch2");
      end
    join
    idle_window("r032 single ch2", 40);
    check("r032 overrun sticky", int'(overrun), 3'b100);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    check("r032 overrun cleared", int'(overrun), 0);
    req_in = 3'b000;
    push_exp(0, 6);
    run_pulse_sb("r032 ch0 fall");

    // Reset in the 10th cycle of a ch2 pulse, request held through release.
    req_in[2] = 1'b1;
    n = 0;
    while (pulse_out == 3'b000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("r033 start_in_time", int'(n < 50), 1);
    tick(9);
    check("r033 pulse cycle10", int'(pulse_out), 3'b100);
    reset = 1'b1;
    tick(1);
    check("r033 pulse after reset", int'(pulse_out), 0);
    check("r033 busy after reset", int'(busy), 0);
    check("r033 pending after reset", int'(pending), 0);
    tick(2);
    reset = 1'b0;
    idle_window("r033 no pulse after release", 20);
    check("r033 pending after release", int'(pending), 0);
    req_in[2] = 1'b0;
    idle_window("r033 ch2 fall ignored", 10);

    // enable=0 blocks latching; then both-edge mode on ch0 gives two pulses.
    enable    = 1'b0;
    req_in[0] = 1'b1;
    tick(6);
    check("r034 disabled pending", int'(pending), 0);
    check("r034 disabled busy", int'(busy), 0);
    req_in[0] = 1'b0;
    idle_window("r034 disabled no pulse", 8);
    check("r034 disabled pending fall", int'(pending), 0);
    enable    = 1'b1;
    req_in[0] = 1'b1;
    push_exp(0, 6);
    push_exp(0, 6);
    tick(3);
    req_in[0] = 1'b0;
    run_pulse_sb("r034 rise");
    run_pulse_sb("r034 fall");
    idle_window("r034 quiet", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
